ifm_pad_loader_1x8: RTL



---
 rtl/ifm_pad_loader_1x8_if.sv | 31 +++
 rtl/ifm_pad_loader_1x8.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ifm_pad_loader_1x8_if.sv
// rtl/ifm_pad_loader_1x8_if.sv - pixel stream and buffer write bus of the IFM pad loader
// master = loader side, slave = stream source / buffer side.
interface ifm_pad_loader_1x8_if #(
    parameter int ADDR_BIT = 15
);
    logic                s_valid;
    logic                s_ready;
    logic [63:0]         s_data;
    logic [ADDR_BIT-2:0] bram_addr_write;
    logic                bram_en_write;
    logic [7:0]          out_0;
    logic [7:0]          out_1;
    logic [7:0]          out_2;
    logic [7:0]          out_3;
    logic [7:0]          out_4;
    logic [7:0]          out_5;
    logic [7:0]          out_6;
    logic [7:0]          out_7;

    modport master (
        input  s_valid, s_data,
        output s_ready, bram_addr_write, bram_en_write,
        output out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, bram_addr_write, bram_en_write,
        input  out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7
    );
endinterface

// File: rtl/ifm_pad_loader_1x8.sv
// rtl/ifm_pad_loader_1x8.sv - zero-padding write loader for the 8-lane ping-pong IFM buffer
// Border generation is built only when IFM_LOADER_PAD_EN is defined; otherwise PAD is treated as 0.
module ifm_pad_loader_1x8 #(
    parameter int IMG_W    = 112,
    parameter int IMG_H    = 112,
    parameter int PAD      = 1,
    parameter int ADDR_BIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic rd_done,
    output logic buf_sel,
    output logic bank_ready,
    output logic busy,
    ifm_pad_loader_1x8_if.master bus
);
    localparam int AW = ADDR_BIT - 1;
`ifdef IFM_LOADER_PAD_EN
    localparam int PAD_E = PAD;
`else
    localparam int PAD_E = 0 * PAD;
`endif
    localparam int GW    = IMG_W + 2 * PAD_E;
    localparam int GH    = IMG_H + 2 * PAD_E;
    localparam int CELLS = GW * GH;
    localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] addr;
    logic          rd_busy;
    logic          en_q;
    logic [AW-1:0] addr_q;
    logic [63:0]   data_q;
    logic          in_fill;
    logic          border;
    logic          issue;
    logic          swap;
    logic [63:0]   wr_data;

    assign in_fill = (state == S_FILL);

`ifdef IFM_LOADER_PAD_EN
    localparam logic [AW-1:0] ROW_LO  = AW'(PAD_E);
    localparam logic [AW-1:0] ROW_HI  = AW'(GH - PAD_E);
    localparam logic [AW-1:0] COL_LO  = AW'(PAD_E);
    localparam logic [AW-1:0] COL_HI  = AW'(GW - PAD_E);
    localparam logic [AW-1:0] COL_END = AW'(GW - 1);

    logic [AW-1:0] row;
    logic [AW-1:0] col;

    assign border  = (row < ROW_LO) || (row >= ROW_HI) || (col < COL_LO) || (col >= COL_HI);
    assign wr_data = border ? 64'd0 : bus.s_data;

    // Row/column walk alongside the linear address so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start)) begin
            row <= '0;
            col <= '0;
        end else if (issue && addr != LAST) begin
            if (col == COL_END) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end
`else
    assign border  = 1'b0;
    assign wr_data = bus.s_data;
`endif

    assign issue       = in_fill && (border || bus.s_valid);
    assign bus.s_ready = in_fill && !border;
    // Evaluated while the last write is on the bus, so that write always lands in the old bank.
    assign swap        = (state == S_WAIT) && (!rd_busy || rd_done);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr       <= '0;
            rd_busy    <= 1'b0;
            buf_sel    <= 1'b0;
            bank_ready <= 1'b0;
            en_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            en_q       <= issue;
            bank_ready <= swap;
            if (issue) begin
                addr_q <= addr;
                data_q <= wr_data;
            end
            if (swap) begin
                buf_sel <= ~buf_sel;
                rd_busy <= 1'b1;
            end else if (rd_done) begin
                rd_busy <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FILL;
                        addr  <= '0;
                    end
                end
                S_FILL: begin
                    if (issue) begin
                        if (addr == LAST) begin
                            state <= S_WAIT;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (swap) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.bram_en_write   = en_q;
    assign bus.bram_addr_write = addr_q;
    assign bus.out_0 = data_q[7:0];
    assign bus.out_1 = data_q[15:8];
    assign bus.out_2 = data_q[23:16];
    assign bus.out_3 = data_q[31:24];
    assign bus.out_4 = data_q[39:32];
    assign bus.out_5 = data_q[47:40];
    assign bus.out_6 = data_q[55:48];
    assign bus.out_7 = data_q[63:56];
endmodule
